msrh_ptw_lsu_requester: RTL
===========================

// Module: msrh_ptw_lsu_requester
// PURPOSE
//  PTW-side initiator of the lsu_access interface; the LSU top is the responder. Accepts one PTE read from
//  the page-table walker, drives req_valid/paddr to L1D, and interprets the 1-cycle-later status.
//  Retries on L1D conflict or miss with backoff, parks on LRQ conflict until the matching LRQ resolve arrives,
//  and returns the XLEN PTE data to the walker over a valid/ready handshake. One request in flight.
// PARAMETERS
//  PADDR_W         56  physical address width
//  XLEN_W          64  PTE/data width
//  LRQ_ENTRY_SIZE   8  LRQ entries; width of the one-hot conflict indices
//  BACKOFF_CYCLES   4  idle cycles before reissue after MISS / L1D_CONFLICT / NONE (>=1)
//  MAX_RETRY       15  reissues allowed before giving up (>=1)
// PORTS
//  i_clk                        in   1               clock
//  i_reset                      in   1               synchronous reset, active-high
//  i_flush                      in   1               abort walk (sfence/satp write)
//  i_walk_req_valid             in   1               walker PTE read request
//  o_walk_req_ready             out  1               request accepted when valid&ready
//  i_walk_req_paddr             in   PADDR_W         PTE physical address
//  o_walk_resp_valid            out  1               result valid
//  i_walk_resp_ready            in   1               walker consumes result
//  o_walk_resp_status           out  1               0=HIT, 1=RETRY_EXHAUSTED
//  o_walk_resp_data             out  XLEN_W          PTE data (valid when status=HIT)
//  o_lsu_req_valid              out  1               lsu_access.req_valid
//  o_lsu_paddr                  out  PADDR_W         lsu_access.paddr
//  i_lsu_resp_valid             in   1               lsu_access.resp_valid (req_valid delayed 1 cycle)
//  i_lsu_status                 in   lsu_status_t    NONE/HIT/MISS/L1D_CONFLICT/LRQ_CONFLICT
//  i_lsu_data                   in   XLEN_W          lsu_access.data
//  i_lsu_lrq_conflicted_idx_oh  in   LRQ_ENTRY_SIZE  LRQ entry blocking us (with LRQ_CONFLICT)
//  i_lsu_resolve_vld            in   1               lsu_access.conflict_resolve_vld
//  i_lsu_resolve_idx_oh         in   LRQ_ENTRY_SIZE  lsu_access.conflict_resolve_idx_oh
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, retry counter 0, latched paddr/data/conflict-oh 0.
//  - States: IDLE, REQ, RESP, BACKOFF, WAIT_LRQ, DONE. o_walk_req_ready=1 only in IDLE (and !i_flush).
//  - IDLE: accept -> latch paddr, retry=0 -> REQ.
//  - REQ: o_lsu_req_valid=1 for exactly one cycle, o_lsu_paddr=latched paddr -> RESP.
//  - RESP (i_lsu_resp_valid required; absent -> stay): HIT -> latch data, status=0 -> DONE.
//    MISS/L1D_CONFLICT/NONE: retry==MAX_RETRY -> status=1 -> DONE; else retry++, load backoff -> BACKOFF.
//    LRQ_CONFLICT: latch conflicted_idx_oh -> WAIT_LRQ; if resolve_vld & |(resolve_idx_oh & conflicted_idx_oh)
//    in the same cycle -> REQ directly (no lost wakeup).
//  - BACKOFF: counter counts BACKOFF_CYCLES down to 0, then REQ. Zero-based: exactly BACKOFF_CYCLES idle cycles.
//  - WAIT_LRQ: resolve_vld & |(resolve_idx_oh & latched oh) -> REQ. Does not increment retry. Non-matching resolves ignored.
//  - DONE: o_walk_resp_valid=1, data/status stable until i_walk_resp_ready; on handshake -> IDLE.
//  - Latency (all hits, ready=1): accept T, lsu req T+1, resp T+2, o_walk_resp_valid T+3.
//  - i_lsu_resp_valid ignored in every state except RESP (stale responses after flush dropped).
//  - i_flush: any state -> IDLE next cycle, o_walk_resp_valid/o_lsu_req_valid deassert next cycle,
//    retry cleared; flush has priority over every other transition incl. DONE handshake same cycle.
//  - Retry counter width $clog2(MAX_RETRY+1); never wraps (saturates via give-up).
//  - i_reset mid-operation: same as flush plus outputs to reset values.
// CONFIGURATION
//  MSRH_PTW_LSU_PERF_EN defined: adds outputs o_perf_req_cnt, o_perf_retry_cnt, o_perf_lrq_wait_cnt (32b each,
//   saturating, cleared on reset only) counting REQ issues, BACKOFF entries and WAIT_LRQ cycles.
//  Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1 accept paddr=0x8000_1000, resp HIT data=0xDEAD_BEEF at T+2 -> resp_valid T+3, status=0, data=0xDEAD_BEEF.
//  2 L1D_CONFLICT twice then HIT -> 3 lsu reqs, each reissue exactly BACKOFF_CYCLES=4 cycles after resp.
//  3 LRQ_CONFLICT oh=0x04; resolve oh=0x02 then 0x04 5 cycles later -> reissue only after 0x04; same-cycle
//    resolve 0x04 with conflict response -> REQ next cycle.
//  4 MISS on every access, MAX_RETRY=15 -> 16 lsu reqs, then status=1; walker holds ready=0 10 cycles -> outputs stable.
//  5 i_flush in RESP while HIT arrives -> no resp_valid; new req next cycle completes normally with its own data.
//  6 i_reset asserted in WAIT_LRQ -> all outputs 0 next cycle, o_walk_req_ready=1 after release.

Source files
------------

// File: rtl/msrh_ptw_lsu_requester_if.sv
// Walker and lsu_access signal bundle of the PTW LSU requester; slave = requester, master = walker/LSU side.
// i_lsu_status encoding: 0=NONE 1=HIT 2=MISS 3=L1D_CONFLICT 4=LRQ_CONFLICT.
interface msrh_ptw_lsu_requester_if #(
    parameter int PADDR_W        = 56,
    parameter int XLEN_W         = 64,
    parameter int LRQ_ENTRY_SIZE = 8
);
    logic                      i_flush;
    logic                      i_walk_req_valid;
    logic                      o_walk_req_ready;
    logic [PADDR_W-1:0]        i_walk_req_paddr;
    logic                      o_walk_resp_valid;
    logic                      i_walk_resp_ready;
    logic                      o_walk_resp_status;
    logic [XLEN_W-1:0]         o_walk_resp_data;
    logic                      o_lsu_req_valid;
    logic [PADDR_W-1:0]        o_lsu_paddr;
    logic                      i_lsu_resp_valid;
    logic [2:0]                i_lsu_status;
    logic [XLEN_W-1:0]         i_lsu_data;
    logic [LRQ_ENTRY_SIZE-1:0] i_lsu_lrq_conflicted_idx_oh;
    logic                      i_lsu_resolve_vld;
    logic [LRQ_ENTRY_SIZE-1:0] i_lsu_resolve_idx_oh;

    modport slave (
        input  i_flush, i_walk_req_valid, i_walk_req_paddr, i_walk_resp_ready,
        input  i_lsu_resp_valid, i_lsu_status, i_lsu_data,
        input  i_lsu_lrq_conflicted_idx_oh, i_lsu_resolve_vld, i_lsu_resolve_idx_oh,
        output o_walk_req_ready, o_walk_resp_valid, o_walk_resp_status, o_walk_resp_data,
        output o_lsu_req_valid, o_lsu_paddr
    );

    modport master (
        output i_flush, i_walk_req_valid, i_walk_req_paddr, i_walk_resp_ready,
        output i_lsu_resp_valid, i_lsu_status, i_lsu_data,
        output i_lsu_lrq_conflicted_idx_oh, i_lsu_resolve_vld, i_lsu_resolve_idx_oh,
        input  o_walk_req_ready, o_walk_resp_valid, o_walk_resp_status, o_walk_resp_data,
        input  o_lsu_req_valid, o_lsu_paddr
    );
endinterface

// File: rtl/msrh_ptw_lsu_requester.sv
// PTW-side lsu_access initiator: one PTE read in flight, backoff retry, LRQ-conflict parking, walker handshake.
// Define MSRH_PTW_LSU_PERF_EN to add saturating request/retry/LRQ-wait performance counters.
module msrh_ptw_lsu_requester #(
    parameter int PADDR_W        = 56,
    parameter int XLEN_W         = 64,
    parameter int LRQ_ENTRY_SIZE = 8,
    parameter int BACKOFF_CYCLES = 4,
    parameter int MAX_RETRY      = 15
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    msrh_ptw_lsu_requester_if.slave       bus
`ifdef MSRH_PTW_LSU_PERF_EN
    ,
    output logic [31:0]                   o_perf_req_cnt,
    output logic [31:0]                   o_perf_retry_cnt,
    output logic [31:0]                   o_perf_lrq_wait_cnt
`endif
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int BO_W    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    localparam logic [2:0] ST_HIT          = 3'd1;
    localparam logic [2:0] ST_LRQ_CONFLICT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RESP, S_BACKOFF, S_WAIT_LRQ, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [BO_W-1:0]           bo_q, bo_d;
    logic [PADDR_W-1:0]        paddr_q, paddr_d;
    logic [XLEN_W-1:0]         data_q, data_d;
    logic [LRQ_ENTRY_SIZE-1:0] oh_q, oh_d;
    logic                      status_q, status_d;
    logic                      resp_match, wait_match;

    // A resolve in the same cycle as the conflict response must not be lost.
    assign resp_match = bus.i_lsu_resolve_vld & |(bus.i_lsu_resolve_idx_oh & bus.i_lsu_lrq_conflicted_idx_oh);
    assign wait_match = bus.i_lsu_resolve_vld & |(bus.i_lsu_resolve_idx_oh & oh_q);

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        bo_d     = bo_q;
        paddr_d  = paddr_q;
        data_d   = data_q;
        oh_d     = oh_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_walk_req_valid && !bus.i_flush) begin
                    paddr_d = bus.i_walk_req_paddr;
                    retry_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_RESP;
            S_RESP: begin
                if (bus.i_lsu_resp_valid) begin
                    if (bus.i_lsu_status == ST_HIT) begin
                        data_d   = bus.i_lsu_data;
                        status_d = 1'b0;
                        state_d  = S_DONE;
                    end else if (bus.i_lsu_status == ST_LRQ_CONFLICT) begin
                        oh_d    = bus.i_lsu_lrq_conflicted_idx_oh;
                        state_d = resp_match ? S_REQ : S_WAIT_LRQ;
                    end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        status_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        bo_d    = BO_W'(BACKOFF_CYCLES - 1);
                        state_d = S_BACKOFF;
                    end
                end
            end
            S_BACKOFF: begin
                if (bo_q == '0) state_d = S_REQ;
                else            bo_d    = bo_q - BO_W'(1);
            end
            S_WAIT_LRQ: begin
                if (wait_match) state_d = S_REQ;
            end
            S_DONE: begin
                if (bus.i_walk_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.i_flush) begin
            state_d = S_IDLE;
            retry_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            retry_q  <= '0;
            bo_q     <= '0;
            paddr_q  <= '0;
            data_q   <= '0;
            oh_q     <= '0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            bo_q     <= bo_d;
            paddr_q  <= paddr_d;
            data_q   <= data_d;
            oh_q     <= oh_d;
            status_q <= status_d;
        end
    end

    assign bus.o_walk_req_ready   = (state_q == S_IDLE) & ~bus.i_flush & ~i_reset;
    assign bus.o_lsu_req_valid    = (state_q == S_REQ);
    assign bus.o_lsu_paddr        = paddr_q;
    assign bus.o_walk_resp_valid  = (state_q == S_DONE);
    assign bus.o_walk_resp_status = status_q;
    assign bus.o_walk_resp_data   = data_q;

`ifdef MSRH_PTW_LSU_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_req_q, perf_retry_q, perf_wait_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_req_q   <= '0;
            perf_retry_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (state_q == S_REQ) perf_req_q <= sat_inc(perf_req_q);
            if (state_q == S_RESP && state_d == S_BACKOFF) perf_retry_q <= sat_inc(perf_retry_q);
            if (state_q == S_WAIT_LRQ) perf_wait_q <= sat_inc(perf_wait_q);
        end
    end

    assign o_perf_req_cnt      = perf_req_q;
    assign o_perf_retry_cnt    = perf_retry_q;
    assign o_perf_lrq_wait_cnt = perf_wait_q;
`endif
endmodule
